bubble_access_sequencer: RTL and testbench

Sequences every bubble access inside BubbleDrive8 from the host's synchronized control strobes (nBSEN, nREPEN, nBOOTEN). It tracks the rotating bubble loop position, turns each replicator pulse into a page-load request to the SPI flash loader, and opens the output window that drives DOUT0/DOUT1 for that page. It sits between the host-side pin inputs and the flash loader / output shifter, clocked by the master clock.

---
 rtl/bubble_access_sequencer_if.sv | 11 +
 rtl/bubble_access_sequencer.sv | 177 +++++++++++++++++
 tb/tb_bubble_access_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bubble_access_sequencer_if.sv
// Page-load handshake between the bubble access sequencer (master) and the
// SPI flash loader (slave).
interface bubble_access_sequencer_if;
    logic        LOAD_REQ;
    logic        LOAD_BOOT;
    logic [11:0] LOAD_PAGE;
    logic        LOAD_ACK;

    modport master (output LOAD_REQ, output LOAD_BOOT, output LOAD_PAGE, input LOAD_ACK);
    modport slave  (input LOAD_REQ, input LOAD_BOOT, input LOAD_PAGE, output LOAD_ACK);
endinterface

// File: rtl/bubble_access_sequencer.sv
// Tracks the bubble loop position, turns replicator strobes into flash page-load
// requests and opens the DOUT output window for each accessed page.
module bubble_access_sequencer #(
    parameter int unsigned POS_MAX   = 2052,
    parameter int unsigned OUT_DELAY = 16,
    parameter int unsigned OUT_LEN   = 512
) (
    input  logic                             MCLK,
    input  logic                             nRESET,
    input  logic                             nBSEN,
    input  logic                             nREPEN,
    input  logic                             nBOOTEN,
    input  logic                             SHIFT_TICK,
    bubble_access_sequencer_if.master        ldr,
    output logic                             OUT_EN,
    output logic [9:0]                       OUT_IDX,
    output logic [11:0]                      POSITION,
    output logic [1:0]                       ERR
);

    localparam int unsigned TCNT_MAX = OUT_DELAY + OUT_LEN;
    localparam int unsigned TW       = $clog2(TCNT_MAX + 1);
    localparam logic [TW-1:0] DLY      = TW'(OUT_DELAY);
    localparam logic [TW-1:0] TCNT_END = TW'(TCNT_MAX);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, OUTPUT} state_t;

    logic          r_bsen_s1, r_bsen_s2;
    logic          r_rep_s1, r_rep_s2, r_rep_prev, r_rep_edge;
    logic          r_boot_s1, r_boot_s2;
    logic [11:0]   r_position;

    state_t        r_state, w_state_nxt;
    logic          r_req, w_req_nxt;
    logic          r_boot, w_boot_nxt;
    logic [11:0]   r_page, w_page_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt, w_tcnt_inc;
    logic          r_abort, w_abort_nxt;
    logic          r_out_en, w_out_en_nxt;
    logic [9:0]    r_out_idx, w_out_idx_nxt;
    logic [1:0]    r_err, w_err_nxt;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_bsen_s1  <= 1'b1;
            r_bsen_s2  <= 1'b1;
            r_rep_s1   <= 1'b1;
            r_rep_s2   <= 1'b1;
            r_rep_prev <= 1'b1;
            r_rep_edge <= 1'b0;
            r_boot_s1  <= 1'b1;
            r_boot_s2  <= 1'b1;
        end else begin
            r_bsen_s1  <= nBSEN;
            r_bsen_s2  <= r_bsen_s1;
            r_rep_s1   <= nREPEN;
            r_rep_s2   <= r_rep_s1;
            r_rep_prev <= r_rep_s2;
            r_rep_edge <= r_rep_prev & ~r_rep_s2;
            r_boot_s1  <= nBOOTEN;
            r_boot_s2  <= r_boot_s1;
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET)
            r_position <= '0;
        else if (SHIFT_TICK && !r_bsen_s2)
            r_position <= (r_position == 12'(POS_MAX)) ? '0 : r_position + 12'd1;
    end

    // Ticks since the replicator edge; saturates so a very late ack cannot wrap it.
    assign w_tcnt_inc = (SHIFT_TICK && (r_tcnt < TCNT_END)) ? r_tcnt + TW'(1) : r_tcnt;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_boot    <= 1'b0;
            r_page    <= '0;
            r_tcnt    <= '0;
            r_abort   <= 1'b0;
            r_out_en  <= 1'b0;
            r_out_idx <= '0;
            r_err     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_boot    <= w_boot_nxt;
            r_page    <= w_page_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_abort   <= w_abort_nxt;
            r_out_en  <= w_out_en_nxt;
            r_out_idx <= w_out_idx_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (!r_bsen_s2) w_state_nxt = SHIFT;
            SHIFT: begin
                if (r_bsen_s2)       w_state_nxt = IDLE;
                else if (r_rep_edge) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (ldr.LOAD_ACK) begin
                    if (r_abort || r_bsen_s2)     w_state_nxt = IDLE;
                    else if (w_tcnt_inc >= TCNT_END) w_state_nxt = SHIFT;
                    else                          w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (r_bsen_s2)                   w_state_nxt = IDLE;
                else if (w_tcnt_inc >= TCNT_END) w_state_nxt = SHIFT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The window index is always derived from ticks since the edge, so a late
    // ack opens mid-window and still closes on the nominal tick.
    always_comb begin
        w_req_nxt     = r_req;
        w_boot_nxt    = r_boot;
        w_page_nxt    = r_page;
        w_tcnt_nxt    = r_tcnt;
        w_abort_nxt   = r_abort;
        w_out_en_nxt  = 1'b0;
        w_out_idx_nxt = r_out_idx;
        w_err_nxt     = r_err;
        unique case (r_state)
            SHIFT: begin
                if (!r_bsen_s2 && r_rep_edge) begin
                    w_req_nxt   = 1'b1;
                    w_page_nxt  = r_position;
                    w_boot_nxt  = ~r_boot_s2;
                    w_tcnt_nxt  = TW'(SHIFT_TICK);
                    w_abort_nxt = 1'b0;
                end
            end
            LOAD: begin
                w_tcnt_nxt = w_tcnt_inc;
                if (r_bsen_s2)  w_abort_nxt  = 1'b1;
                if (r_rep_edge) w_err_nxt[1] = 1'b1;
                if (ldr.LOAD_ACK) begin
                    w_req_nxt = 1'b0;
                    if (!(r_abort || r_bsen_s2) && (w_tcnt_inc >= DLY) && (w_tcnt_inc < TCNT_END)) begin
                        w_out_en_nxt  = 1'b1;
                        w_out_idx_nxt = 10'(w_tcnt_inc - DLY);
                    end
                end else if (w_tcnt_inc >= DLY) begin
                    w_err_nxt[0] = 1'b1;
                end
            end
            OUTPUT: begin
                w_tcnt_nxt = w_tcnt_inc;
                if (r_rep_edge) w_err_nxt[1] = 1'b1;
                if (!r_bsen_s2 && (w_tcnt_inc >= DLY) && (w_tcnt_inc < TCNT_END)) begin
                    w_out_en_nxt  = 1'b1;
                    w_out_idx_nxt = 10'(w_tcnt_inc - DLY);
                end
            end
            default: ;
        endcase
    end

    assign ldr.LOAD_REQ  = r_req;
    assign ldr.LOAD_BOOT = r_boot;
    assign ldr.LOAD_PAGE = r_page;
    assign OUT_EN        = r_out_en;
    assign OUT_IDX       = r_out_idx;
    assign POSITION      = r_position;
    assign ERR           = r_err;

endmodule

// File: tb/tb_bubble_access_sequencer.sv
// Scoreboard bench for bubble_access_sequencer: directed accesses push expected
// load handshakes and output windows; a monitor checks them as the DUT presents them.
module tb_bubble_access_sequencer;

    logic        MCLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        nBSEN = 1'b1;
    logic        nREPEN = 1'b1;
    logic        nBOOTEN = 1'b1;
    logic        SHIFT_TICK = 1'b0;
    logic        OUT_EN;
    logic [9:0]  OUT_IDX;
    logic [11:0] POSITION;
    logic [1:0]  ERR;

    bubble_access_sequencer_if ldr();

    bubble_access_sequencer #(
        .POS_MAX  (2052),
        .OUT_DELAY(16),
        .OUT_LEN  (512)
    ) dut (
        .MCLK      (MCLK),
        .nRESET    (nRESET),
        .nBSEN     (nBSEN),
        .nREPEN    (nREPEN),
        .nBOOTEN   (nBOOTEN),
        .SHIFT_TICK(SHIFT_TICK),
        .ldr       (ldr),
        .OUT_EN    (OUT_EN),
        .OUT_IDX   (OUT_IDX),
        .POSITION  (POSITION),
        .ERR       (ERR)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {logic [11:0] page; logic boot;} load_exp_t;
    typedef struct {int unsigned first; int unsigned last;} win_exp_t;

    load_exp_t q_load[$];
    win_exp_t  q_win[$];

    int total = 0;
    int bad   = 0;
    int rep_left = 0;
    int req_hi = 0;

    logic        mon_en_q = 1'b0;
    logic [9:0]  mon_idx_q = '0;
    int unsigned mon_last = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge MCLK);
        #1;
        if (rep_left > 0) begin
            rep_left--;
            if (rep_left == 0) nREPEN = 1'b1;
        end
        req_hi += int'(ldr.LOAD_REQ);
    endtask

    task automatic tick();
        SHIFT_TICK = 1'b1;
        cyc();
        SHIFT_TICK = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_rep(input int len);
        nREPEN   = 1'b0;
        rep_left = len;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 8 && !ldr.LOAD_REQ; i++) cyc();
        check(name, 32'(ldr.LOAD_REQ), 1);
    endtask

    task automatic ack();
        ldr.LOAD_ACK = 1'b1;
        cyc();
        ldr.LOAD_ACK = 1'b0;
    endtask

    task automatic exp_load(input logic [11:0] page, input logic boot);
        load_exp_t e;
        e.page = page;
        e.boot = boot;
        q_load.push_back(e);
    endtask

    task automatic exp_win(input int unsigned first, input int unsigned last);
        win_exp_t w;
        w.first = first;
        w.last  = last;
        q_win.push_back(w);
    endtask

    // Monitor: checks each accepted load and each output window as it appears.
    initial begin
        load_exp_t e;
        win_exp_t  w;
        forever begin
            @(negedge MCLK);
            if (ldr.LOAD_REQ && ldr.LOAD_ACK) begin
                if (q_load.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_load: got page %0d, expected no load", ldr.LOAD_PAGE);
                end else begin
                    e = q_load.pop_front();
                    check("load_page", 32'(ldr.LOAD_PAGE), 32'(e.page));
                    check("load_boot", 32'(ldr.LOAD_BOOT), 32'(e.boot));
                end
            end
            if (OUT_EN && !mon_en_q) begin
                if (q_win.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_window: got idx %0d, expected no window", OUT_IDX);
                end else begin
                    w = q_win.pop_front();
                    check("win_first", 32'(OUT_IDX), w.first);
                    mon_last = w.last;
                end
            end else if (OUT_EN && mon_en_q && (OUT_IDX != mon_idx_q)) begin
                check("win_step", 32'(OUT_IDX), 32'(mon_idx_q) + 1);
            end else if (!OUT_EN && mon_en_q) begin
                check("win_last", 32'(mon_idx_q), mon_last);
            end
            mon_en_q  = OUT_EN;
            mon_idx_q = OUT_IDX;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pos;
        ldr.LOAD_ACK = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
        check("rst_req",  32'(ldr.LOAD_REQ), 0);
        check("rst_boot", 32'(ldr.LOAD_BOOT), 0);
        check("rst_page", 32'(ldr.LOAD_PAGE), 0);
        check("rst_en",   32'(OUT_EN), 0);
        check("rst_idx",  32'(OUT_IDX), 0);
        check("rst_pos",  32'(POSITION), 0);
        check("rst_err",  32'(ERR), 0);
        nRESET = 1'b1;
        cyc();

        // Position wrap, then boot-loop access at position 0
        nBSEN = 1'b0;
        nBOOTEN = 1'b0;
        repeat (4) cyc();
        for (int i = 1; i <= 2053; i++) begin
            tick();
            exp_pos = (i == 2053) ? 32'd0 : 32'(i);
            check("pos_wrap", 32'(POSITION), exp_pos);
        end
        exp_load(12'd0, 1'b1);
        exp_win(0, 511);
        start_rep(20);
        wait_req("boot_req");
        repeat (2) cyc();
        ack();
        ticks(528);
        check("boot_err", 32'(ERR), 0);
        check("boot_closed", 32'(OUT_EN), 0);
        check("boot_pos", 32'(POSITION), 528);

        // Normal page access at 181
        nBOOTEN = 1'b1;
        ticks(1706);
        check("pos_181", 32'(POSITION), 181);
        exp_load(12'd181, 1'b0);
        exp_win(0, 511);
        start_rep(683);
        repeat (3) cyc();
        check("req_lat3", 32'(ldr.LOAD_REQ), 0);
        cyc();
        check("req_lat4", 32'(ldr.LOAD_REQ), 1);
        repeat (4) cyc();
        check("req_hold", 32'(ldr.LOAD_REQ), 1);
        ack();
        check("req_drop", 32'(ldr.LOAD_REQ), 0);
        ticks(15);
        check("en_tick15", 32'(OUT_EN), 0);
        tick();
        check("en_tick16", 32'(OUT_EN), 1);
        check("idx_tick16", 32'(OUT_IDX), 0);
        ticks(511);
        check("idx_end", 32'(OUT_IDX), 511);
        tick();
        check("norm_closed", 32'(OUT_EN), 0);
        check("norm_pos", 32'(POSITION), 709);

        // Late ack: 20 ticks after the edge
        exp_load(12'd709, 1'b0);
        exp_win(4, 511);
        start_rep(20);
        wait_req("late_req");
        ticks(20);
        check("late_err", 32'(ERR), 1);
        check("late_en_pre", 32'(OUT_EN), 0);
        ack();
        check("late_en", 32'(OUT_EN), 1);
        check("late_idx", 32'(OUT_IDX), 4);
        ticks(507);
        check("late_idx_end", 32'(OUT_IDX), 511);
        tick();
        check("late_closed", 32'(OUT_EN), 0);
        check("late_pos", 32'(POSITION), 1237);

        // Overrun: second replicator pulse inside the window
        exp_load(12'd1237, 1'b0);
        exp_win(0, 511);
        start_rep(20);
        wait_req("ovr_req");
        repeat (2) cyc();
        ack();
        ticks(100);
        req_hi = 0;
        start_rep(10);
        ticks(10);
        check("ovr_err", 32'(ERR), 3);
        check("ovr_idx", 32'(OUT_IDX), 94);
        ticks(418);
        check("ovr_no_req", 32'(req_hi), 0);
        check("ovr_closed", 32'(OUT_EN), 0);
        check("ovr_pos", 32'(POSITION), 1765);

        // Abort while the request is pending
        exp_load(12'd1765, 1'b0);
        start_rep(20);
        wait_req("abt_req");
        nBSEN = 1'b1;
        repeat (10) cyc();
        check("abt_req_held", 32'(ldr.LOAD_REQ), 1);
        ack();
        check("abt_req_drop", 32'(ldr.LOAD_REQ), 0);
        ticks(5);
        check("abt_pos_frozen", 32'(POSITION), 1765);
        check("abt_no_win", 32'(OUT_EN), 0);

        // Abort in the middle of the window
        nBSEN = 1'b0;
        repeat (4) cyc();
        exp_load(12'd1765, 1'b0);
        exp_win(0, 14);
        start_rep(20);
        wait_req("abw_req");
        repeat (2) cyc();
        ack();
        ticks(30);
        check("abw_idx", 32'(OUT_IDX), 14);
        nBSEN = 1'b1;
        repeat (2) cyc();
        check("abw_en_hold", 32'(OUT_EN), 1);
        cyc();
        check("abw_en_drop", 32'(OUT_EN), 0);
        ticks(3);
        check("abw_pos", 32'(POSITION), 1795);

        // Asynchronous reset with a request pending
        nBSEN = 1'b0;
        repeat (4) cyc();
        start_rep(40);
        wait_req("rst2_req");
        #2;
        nRESET = 1'b0;
        #1;
        check("rst2_req",  32'(ldr.LOAD_REQ), 0);
        check("rst2_page", 32'(ldr.LOAD_PAGE), 0);
        check("rst2_pos",  32'(POSITION), 0);
        check("rst2_err",  32'(ERR), 0);
        check("rst2_en",   32'(OUT_EN), 0);
        rep_left = 0;
        nREPEN = 1'b1;
        @(posedge MCLK);
        #1;
        nRESET = 1'b1;
        req_hi = 0;
        repeat (8) cyc();
        check("rst2_no_req", 32'(req_hi), 0);

        check("q_load_empty", 32'(q_load.size()), 0);
        check("q_win_empty", 32'(q_win.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
